// File: rtl/mem_parity_slave.sv
// Memory-side bus slave storing bytes with an even-XOR parity bit.
// Flags parity errors, reads of unwritten locations and read/write conflicts.
module mem_parity_slave #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic              read,
    input  logic [ADDR_W-1:0] address,
    input  logic [7:0]        data_in,
    input  logic              inj_par_err,
    output logic [8:0]        data_out,
    output logic              rd_valid,
    output logic              par_err,
    output logic              uninit_rd,
    output logic              rw_conflict,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [8:0]       mem [DEPTH];
    logic [DEPTH-1:0] written;

    logic       wr_en;
    logic       rd_en;
    logic       conflict;
    logic [8:0] rd_word;
    logic       rd_hit;
    logic [8:0] wr_word;

    // Decode the strobes; a sampled reset suppresses every operation.
    always_comb begin
        wr_en    = write & ~read & ~reset;
        rd_en    = read & ~write & ~reset;
        conflict = write & read & ~reset;
        rd_word  = mem[address];
        rd_hit   = written[address];
        wr_word  = {(^data_in) ^ inj_par_err, data_in};
    end

    // Storage array; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[address] <= wr_word;
        end
    end

    // Written bitmap marks locations that hold valid data since reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            written <= '0;
        end else if (wr_en) begin
            written[address] <= 1'b1;
        end
    end

    // Registered read response and single-cycle status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out    <= 9'h000;
            rd_valid    <= 1'b0;
            par_err     <= 1'b0;
            uninit_rd   <= 1'b0;
            rw_conflict <= 1'b0;
        end else begin
            rd_valid    <= rd_en;
            rw_conflict <= conflict;
            par_err     <= 1'b0;
            uninit_rd   <= 1'b0;
            if (rd_en) begin
                if (rd_hit) begin
                    data_out <= rd_word;
                    par_err  <= rd_word[8] ^ (^rd_word[7:0]);
                end else begin
                    data_out  <= 9'h000;
                    uninit_rd <= 1'b1;
                end
            end
        end
    end

    // Saturating count of read/write conflicts.
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if (conflict && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_mem_parity_slave.sv
// Randomized self-checking bench for mem_parity_slave.
// A second narrow instance exercises counter saturation.
module tb_mem_parity_slave;

    logic        clk;
    logic        reset;
    logic        write;
    logic        read;
    logic [15:0] address;
    logic [7:0]  data_in;
    logic        inj_par_err;

    logic [8:0]  data_out;
    logic        rd_valid;
    logic        par_err;
    logic        uninit_rd;
    logic        rw_conflict;
    logic [7:0]  conflict_cnt;

    logic [8:0]  b_data_out;
    logic        b_rd_valid;
    logic        b_par_err;
    logic        b_uninit_rd;
    logic        b_rw_conflict;
    logic [1:0]  b_conflict_cnt;

    int n_cmp;
    int n_bad;

    logic [8:0] ref_mem [int];
    logic [8:0] e_dout;
    logic       e_rv;
    logic       e_pe;
    logic       e_un;
    logic       e_rc;
    int         e_cnt;
    int         e_cnt2;

    mem_parity_slave #(.ADDR_W(16), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .write       (write),
        .read        (read),
        .address     (address),
        .data_in     (data_in),
        .inj_par_err (inj_par_err),
        .data_out    (data_out),
        .rd_valid    (rd_valid),
        .par_err     (par_err),
        .uninit_rd   (uninit_rd),
        .rw_conflict (rw_conflict),
        .conflict_cnt(conflict_cnt)
    );

    mem_parity_slave #(.ADDR_W(4), .CNT_W(2)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .write       (write),
        .read        (read),
        .address     (address[3:0]),
        .data_in     (data_in),
        .inj_par_err (inj_par_err),
        .data_out    (b_data_out),
        .rd_valid    (b_rd_valid),
        .par_err     (b_par_err),
        .uninit_rd   (b_uninit_rd),
        .rw_conflict (b_rw_conflict),
        .conflict_cnt(b_conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // One bus cycle: drive, clock, advance the reference, compare.
    task automatic cyc(input bit rst, input bit w, input bit r,
                       input logic [15:0] a, input logic [7:0] d,
                       input bit inj);
        reset       = rst;
        write       = w;
        read        = r;
        address     = a;
        data_in     = d;
        inj_par_err = inj;
        @(posedge clk);
        #1;
        e_rv = 1'b0;
        e_pe = 1'b0;
        e_un = 1'b0;
        e_rc = 1'b0;
        if (rst) begin
            ref_mem.delete();
            e_dout = 9'h000;
            e_cnt  = 0;
            e_cnt2 = 0;
        end else if (w && r) begin
            e_rc   = 1'b1;
            e_cnt  = (e_cnt < 255) ? e_cnt + 1 : 255;
            e_cnt2 = (e_cnt2 < 3) ? e_cnt2 + 1 : 3;
        end else if (w) begin
            ref_mem[int'(a)] = {(^d) ^ inj, d};
        end else if (r) begin
            e_rv = 1'b1;
            if (ref_mem.exists(int'(a))) begin
                e_dout = ref_mem[int'(a)];
                e_pe   = ^e_dout;
            end else begin
                e_dout = 9'h000;
                e_un   = 1'b1;
            end
        end
        chk("data_out", 32'(data_out), 32'(e_dout));
        chk("rd_valid", 32'(rd_valid), 32'(e_rv));
        chk("par_err", 32'(par_err), 32'(e_pe));
        chk("uninit_rd", 32'(uninit_rd), 32'(e_un));
        chk("rw_conflict", 32'(rw_conflict), 32'(e_rc));
        chk("conflict_cnt", 32'(conflict_cnt), 32'(e_cnt));
        chk("b_rd_valid", 32'(b_rd_valid), 32'(e_rv));
        chk("b_rw_conflict", 32'(b_rw_conflict), 32'(e_rc));
        chk("b_conflict_cnt", 32'(b_conflict_cnt), 32'(e_cnt2));
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d,
                      input bit inj);
        cyc(1'b0, 1'b1, 1'b0, a, d, inj);
    endtask

    task automatic rd(input logic [15:0] a);
        cyc(1'b0, 1'b0, 1'b1, a, 8'h00, 1'b0);
    endtask

    initial begin
        int sat_exp [5];
        logic [15:0] pool [8];
        n_cmp  = 0;
        n_bad  = 0;
        e_cnt  = 0;
        e_cnt2 = 0;
        e_dout = 9'h000;
        sat_exp = '{1, 2, 3, 3, 3};
        pool = '{16'h0000, 16'h0001, 16'h0010, 16'h00ff,
                 16'h1234, 16'h8000, 16'hfffe, 16'hffff};

        reset = 1'b1; write = 1'b0; read = 1'b0;
        address = '0; data_in = '0; inj_par_err = 1'b0;

        // Reset, including a write that must be ignored.
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 16'h0050, 8'h77, 1'b0);
        chk("reset_dout", 32'(data_out), 32'h000);
        chk("reset_cnt", 32'(conflict_cnt), 32'h0);
        rd(16'h0050);
        chk("rst_write_ignored", 32'(uninit_rd), 32'h1);

        wr(16'h0010, 8'ha5, 1'b0);
        rd(16'h0010);
        chk("tp1_dout", 32'(data_out), 32'h0a5);

        wr(16'hffff, 8'h01, 1'b0);
        rd(16'hffff);
        chk("tp2_dout", 32'(data_out), 32'h101);
        rd(16'h0000);
        chk("tp2_uninit", 32'(uninit_rd), 32'h1);

        wr(16'h0020, 8'h03, 1'b1);
        rd(16'h0020);
        chk("tp3_inj_dout", 32'(data_out), 32'h103);
        chk("tp3_inj_perr", 32'(par_err), 32'h1);
        wr(16'h0020, 8'h03, 1'b0);
        rd(16'h0020);
        chk("tp3_clr_dout", 32'(data_out), 32'h003);

        wr(16'h0030, 8'h11, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 16'h0030, 8'h22, 1'b1);
        chk("tp4_conflict", 32'(rw_conflict), 32'h1);
        chk("tp4_cnt", 32'(conflict_cnt), 32'h1);
        rd(16'h0030);
        chk("tp4_unchanged", 32'(data_out), 32'h011);

        // Saturation on the 2-bit counter.
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 16'h0001, 8'h00, 1'b0);
            chk("tp5_sat", 32'(b_conflict_cnt), 32'(sat_exp[i]));
        end

        // Reset clears the written bitmap.
        wr(16'h0040, 8'h5a, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        rd(16'h0040);
        chk("tp6_uninit", 32'(uninit_rd), 32'h1);
        chk("tp6_cnt", 32'(conflict_cnt), 32'h0);

        // Back-to-back reads, then reset mid-stream.
        wr(16'h0040, 8'h5a, 1'b0);
        rd(16'h0040);
        rd(16'h0040);
        rd(16'h0040);
        cyc(1'b1, 1'b0, 1'b1, 16'h0040, 8'h00, 1'b0);

        // Randomized traffic over a small address pool.
        for (int i = 0; i < 600; i++) begin
            int op;
            logic [15:0] a;
            op = int'($urandom_range(0, 9));
            a  = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                             : pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 79) == 0)
                cyc(1'b1, 1'($urandom), 1'($urandom), a,
                    8'($urandom), 1'($urandom));
            else if (op < 4)
                wr(a, 8'($urandom), ($urandom_range(0, 4) == 0));
            else if (op < 8)
                rd(a);
            else if (op == 8)
                cyc(1'b0, 1'b1, 1'b1, a, 8'($urandom), 1'($urandom));
            else
                cyc(1'b0, 1'b0, 1'b0, a, 8'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
